// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared types and constants for the branch redirect controller and its training FIFO.
package branch_redirect_ctrl_pkg;

    // Redirect sequencer states.
    typedef enum logic [1:0] {
        REDIR_IDLE  = 2'd0,
        REDIR_BUSY  = 2'd1,
        REDIR_DRAIN = 2'd2
    } redir_state_t;

    // Fixed instruction size; a not-taken branch falls through by this many bytes.
    localparam int BR_INSN_BYTES = 4;

    // Both pipes can resolve in the same cycle, so issue must stall once fewer
    // than this many training slots remain.
    localparam int UPD_PUSH_MAX = 2;

endpackage

// File: rtl/branch_upd_fifo.sv
// Predictor-training FIFO: up to two writes and one read per cycle.
// Pointers carry one extra wrap bit so full and empty stay distinguishable.
module branch_upd_fifo
    import branch_redirect_ctrl_pkg::*;
#(
    parameter int DATA_W    = 66,
    parameter int UPD_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr0_en,
    input  logic [DATA_W-1:0] wr0_data,
    input  logic              wr1_en,
    input  logic [DATA_W-1:0] wr1_data,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              rd_ready,
    output logic              low_space
);

    localparam int PTR_W = $clog2(UPD_DEPTH);

    logic [DATA_W-1:0] mem [UPD_DEPTH];
    logic [PTR_W:0]    wr_ptr;
    logic [PTR_W:0]    rd_ptr;
    logic [PTR_W:0]    count;
    logic [PTR_W:0]    wr_ptr_p1;
    logic [PTR_W:0]    push_cnt;
    logic [DATA_W-1:0] first_data;
    logic              empty;
    logic              pop;

    assign count      = wr_ptr - rd_ptr;
    assign empty      = (count == '0);
    assign pop        = !empty && rd_ready;
    assign wr_ptr_p1  = wr_ptr + (PTR_W+1)'(1);
    assign push_cnt   = (PTR_W+1)'(wr0_en) + (PTR_W+1)'(wr1_en);
    // A lone pipe1 record takes the first free slot.
    assign first_data = wr0_en ? wr0_data : wr1_data;

    assign rd_valid  = !empty;
    assign rd_data   = empty ? '0 : mem[rd_ptr[PTR_W-1:0]];
    assign low_space = (count > (PTR_W+1)'(UPD_DEPTH - UPD_PUSH_MAX));

    // Storage writes; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (wr0_en || wr1_en) begin
            mem[wr_ptr[PTR_W-1:0]] <= first_data;
        end
        if (wr0_en && wr1_en) begin
            mem[wr_ptr_p1[PTR_W-1:0]] <= wr1_data;
        end
    end

    // Pointer update for 0/1/2 pushes and an optional pop in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr + push_cnt;
            if (pop) begin
                rd_ptr <= rd_ptr + (PTR_W+1)'(1);
            end
        end
    end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Collects resolved branches from both execute pipes, redirects the frontend on the
// oldest mispredict and queues one training record per resolved branch.
//
// state       | meaning
// REDIR_IDLE  | accepting branch results, no redirect outstanding
// REDIR_BUSY  | redirect PC presented to the frontend until accepted
// REDIR_DRAIN | one cycle after acceptance before results are accepted again
module branch_redirect_ctrl
    import branch_redirect_ctrl_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int UPD_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              br0_valid,
    input  logic [ADDR_W-1:0] br0_pc,
    input  logic              br0_taken,
    input  logic [ADDR_W-1:0] br0_target,
    input  logic              br0_pred_taken,
    input  logic [ADDR_W-1:0] br0_pred_target,
    input  logic              br0_is_jirl,
    input  logic              br1_valid,
    input  logic [ADDR_W-1:0] br1_pc,
    input  logic              br1_taken,
    input  logic [ADDR_W-1:0] br1_target,
    input  logic              br1_pred_taken,
    input  logic [ADDR_W-1:0] br1_pred_target,
    input  logic              br1_is_jirl,
    output logic              redir_valid,
    output logic [ADDR_W-1:0] redir_pc,
    input  logic              redir_ready,
    output logic              flush,
    output logic              busy,
    output logic              upd_valid,
    output logic [ADDR_W-1:0] upd_pc,
    output logic [ADDR_W-1:0] upd_target,
    output logic              upd_taken,
    output logic              upd_is_jirl,
    input  logic              upd_ready
);

    localparam int REC_W = 2*ADDR_W + 2;

    redir_state_t      state;
    logic              in_idle;
    logic              mp0;
    logic              mp1;
    logic [ADDR_W-1:0] fix0;
    logic [ADDR_W-1:0] fix1;
    logic              push0;
    logic              push1;
    logic              fifo_low_space;
    logic [REC_W-1:0]  rec0;
    logic [REC_W-1:0]  rec1;
    logic [REC_W-1:0]  head;

    assign in_idle = (state == REDIR_IDLE);

    assign mp0 = br0_valid && ((br0_taken != br0_pred_taken) ||
                               (br0_taken && (br0_target != br0_pred_target)));
    assign mp1 = br1_valid && ((br1_taken != br1_pred_taken) ||
                               (br1_taken && (br1_target != br1_pred_target)));

    assign fix0 = br0_taken ? br0_target : br0_pc + ADDR_W'(BR_INSN_BYTES);
    assign fix1 = br1_taken ? br1_target : br1_pc + ADDR_W'(BR_INSN_BYTES);

    // Results outside IDLE are wrong-path; pipe1 is also wrong-path behind a pipe0 mispredict.
    assign push0 = in_idle && br0_valid;
    assign push1 = in_idle && br1_valid && !mp0;

    assign rec0 = {br0_pc, br0_target, br0_taken, br0_is_jirl};
    assign rec1 = {br1_pc, br1_target, br1_taken, br1_is_jirl};

    branch_upd_fifo #(
        .DATA_W    (REC_W),
        .UPD_DEPTH (UPD_DEPTH)
    ) u_upd_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr0_en    (push0),
        .wr0_data  (rec0),
        .wr1_en    (push1),
        .wr1_data  (rec1),
        .rd_valid  (upd_valid),
        .rd_data   (head),
        .rd_ready  (upd_ready),
        .low_space (fifo_low_space)
    );

    assign upd_pc      = head[REC_W-1 -: ADDR_W];
    assign upd_target  = head[ADDR_W+1 -: ADDR_W];
    assign upd_taken   = head[1];
    assign upd_is_jirl = head[0];

    assign busy = !in_idle || fifo_low_space;

    // Redirect sequencer: latch the oldest fix PC, pulse flush once, hold until accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= REDIR_IDLE;
            redir_valid <= 1'b0;
            redir_pc    <= '0;
            flush       <= 1'b0;
        end else begin
            flush <= 1'b0;
            case (state)
                REDIR_IDLE: begin
                    if (mp0 || mp1) begin
                        redir_pc    <= mp0 ? fix0 : fix1;
                        redir_valid <= 1'b1;
                        flush       <= 1'b1;
                        state       <= REDIR_BUSY;
                    end
                end
                REDIR_BUSY: begin
                    if (redir_ready) begin
                        redir_valid <= 1'b0;
                        state       <= REDIR_DRAIN;
                    end
                end
                REDIR_DRAIN: begin
                    state <= REDIR_IDLE;
                end
                default: begin
                    redir_valid <= 1'b0;
                    state       <= REDIR_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed and randomized checks of branch_redirect_ctrl against a queue-based model.
module tb_branch_redirect_ctrl;

    localparam int AW    = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          br0_valid, br0_taken, br0_pred_taken, br0_is_jirl;
    logic [AW-1:0] br0_pc, br0_target, br0_pred_target;
    logic          br1_valid, br1_taken, br1_pred_taken, br1_is_jirl;
    logic [AW-1:0] br1_pc, br1_target, br1_pred_target;
    logic          redir_valid, redir_ready, flush, busy;
    logic [AW-1:0] redir_pc;
    logic          upd_valid, upd_taken, upd_is_jirl, upd_ready;
    logic [AW-1:0] upd_pc, upd_target;

    always #5 clk = ~clk;

    branch_redirect_ctrl #(.ADDR_W(AW), .UPD_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .br0_valid(br0_valid), .br0_pc(br0_pc), .br0_taken(br0_taken),
        .br0_target(br0_target), .br0_pred_taken(br0_pred_taken),
        .br0_pred_target(br0_pred_target), .br0_is_jirl(br0_is_jirl),
        .br1_valid(br1_valid), .br1_pc(br1_pc), .br1_taken(br1_taken),
        .br1_target(br1_target), .br1_pred_taken(br1_pred_taken),
        .br1_pred_target(br1_pred_target), .br1_is_jirl(br1_is_jirl),
        .redir_valid(redir_valid), .redir_pc(redir_pc), .redir_ready(redir_ready),
        .flush(flush), .busy(busy),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target),
        .upd_taken(upd_taken), .upd_is_jirl(upd_is_jirl), .upd_ready(upd_ready)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] target;
        logic        taken;
        logic        jirl;
    } rec_t;

    // Model: outstanding training records, and whether a redirect is pending or draining.
    rec_t        q[$];
    bit          m_pending = 0;
    bit          m_drain   = 0;
    bit          m_flush   = 0;
    logic [31:0] m_pc      = '0;

    function automatic bit is_mp(logic v, logic t, logic pt, logic [31:0] tg, logic [31:0] ptg);
        return v && ((t != pt) || (t && (tg != ptg)));
    endfunction

    function automatic logic [31:0] fix_of(logic [31:0] pc, logic t, logic [31:0] tg);
        logic [31:0] seq;
        seq = pc + 32'd4;
        return t ? tg : seq;
    endfunction

    function automatic bit m_busy();
        return m_pending || m_drain || ((DEPTH - int'(q.size())) < 2);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_br();
        br0_valid = 0; br0_pc = '0; br0_taken = 0; br0_target = '0;
        br0_pred_taken = 0; br0_pred_target = '0; br0_is_jirl = 0;
        br1_valid = 0; br1_pc = '0; br1_taken = 0; br1_target = '0;
        br1_pred_taken = 0; br1_pred_target = '0; br1_is_jirl = 0;
    endtask

    task automatic set_br0(input logic [31:0] pc, input logic t, input logic [31:0] tg,
                           input logic pt, input logic [31:0] ptg, input logic j);
        br0_valid = 1; br0_pc = pc; br0_taken = t; br0_target = tg;
        br0_pred_taken = pt; br0_pred_target = ptg; br0_is_jirl = j;
    endtask

    task automatic set_br1(input logic [31:0] pc, input logic t, input logic [31:0] tg,
                           input logic pt, input logic [31:0] ptg, input logic j);
        br1_valid = 1; br1_pc = pc; br1_taken = t; br1_target = tg;
        br1_pred_taken = pt; br1_pred_target = ptg; br1_is_jirl = j;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        bit   idle;
        bit   mp0;
        bit   mp1;
        rec_t r;
        if (rst) begin
            q.delete();
            m_pending = 0;
            m_drain   = 0;
            m_flush   = 0;
            return;
        end
        idle    = !m_pending && !m_drain;
        m_flush = 0;
        if (q.size() > 0 && upd_ready) void'(q.pop_front());
        if (idle) begin
            mp0 = is_mp(br0_valid, br0_taken, br0_pred_taken, br0_target, br0_pred_target);
            mp1 = is_mp(br1_valid, br1_taken, br1_pred_taken, br1_target, br1_pred_target);
            if (br0_valid) begin
                r = '{br0_pc, br0_target, br0_taken, br0_is_jirl};
                q.push_back(r);
            end
            if (br1_valid && !mp0) begin
                r = '{br1_pc, br1_target, br1_taken, br1_is_jirl};
                q.push_back(r);
            end
            if (mp0 || mp1) begin
                m_pending = 1;
                m_flush   = 1;
                m_pc      = mp0 ? fix_of(br0_pc, br0_taken, br0_target)
                                : fix_of(br1_pc, br1_taken, br1_target);
            end
        end else if (m_pending) begin
            if (redir_ready) begin
                m_pending = 0;
                m_drain   = 1;
            end
        end else begin
            m_drain = 0;
        end
    endtask

    // One clock: protocol check, model update, edge, then compare all outputs.
    task automatic cycle();
        if (!rst && (br0_valid || br1_valid)) check("protocol_br_while_busy", busy, 1'b0);
        model_step();
        @(posedge clk);
        #1;
        check("redir_valid", redir_valid, m_pending);
        check("flush", flush, m_flush);
        check("busy", busy, m_busy());
        check("upd_valid", upd_valid, q.size() > 0);
        if (m_pending) check("redir_pc", redir_pc, m_pc);
        if (q.size() > 0) begin
            check("upd_pc", upd_pc, q[0].pc);
            check("upd_target", upd_target, q[0].target);
            check("upd_taken", upd_taken, q[0].taken);
            check("upd_is_jirl", upd_is_jirl, q[0].jirl);
        end
    endtask

    task automatic rand_br(output logic [31:0] pc, output logic t, output logic [31:0] tg,
                           output logic pt, output logic [31:0] ptg, output logic j);
        logic [31:0] raw;
        raw = $urandom;
        pc  = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : (raw & 32'hFFFF_FFFC);
        raw = $urandom;
        tg  = raw & 32'hFFFF_FFFC;
        t   = 1'($urandom_range(0, 1));
        pt  = ($urandom_range(0, 4) == 0) ? !t : t;
        ptg = ($urandom_range(0, 4) == 0) ? (tg ^ 32'h0000_0040) : tg;
        j   = 1'($urandom_range(0, 1));
    endtask

    initial begin
        logic [31:0] pc, tg, ptg;
        logic        t, pt, j;

        rst = 1; redir_ready = 0; upd_ready = 0;
        clear_br();
        cycle();
        check("rst_redir_pc", redir_pc, 32'h0);
        rst = 0;
        cycle();

        // 1: single taken mispredict on pipe0
        redir_ready = 1;
        set_br0(32'h1C00_0000, 1, 32'h1C00_0100, 0, 32'h0, 0);
        cycle();
        clear_br();
        check("t1_flush", flush, 1'b1);
        check("t1_redir_valid", redir_valid, 1'b1);
        check("t1_redir_pc", redir_pc, 32'h1C00_0100);
        check("t1_upd_pc", upd_pc, 32'h1C00_0000);
        cycle();
        check("t1_drain_redir_valid", redir_valid, 1'b0);
        check("t1_drain_busy", busy, 1'b1);
        cycle();

        // 2: both pipes mispredict, pipe1 discarded
        set_br0(32'h1C00_0200, 0, 32'h1C00_0300, 1, 32'h1C00_0300, 0);
        set_br1(32'h1C00_0204, 1, 32'h1C00_0400, 0, 32'h0, 1);
        cycle();
        clear_br();
        check("t2_redir_pc", redir_pc, 32'h1C00_0204);
        repeat (2) cycle();
        upd_ready = 1;
        repeat (3) cycle();
        upd_ready = 0;

        // 3: pipe1-only not-taken mispredict, both records pushed in order
        set_br0(32'h1C00_0004, 0, 32'h1C00_0040, 0, 32'h1C00_0040, 0);
        set_br1(32'h1C00_0008, 0, 32'h1C00_0080, 1, 32'h1C00_0080, 0);
        cycle();
        clear_br();
        check("t3_redir_pc", redir_pc, 32'h1C00_000C);
        check("t3_head_br0", upd_pc, 32'h1C00_0004);
        repeat (2) cycle();
        upd_ready = 1;
        cycle();
        check("t3_second_br1", upd_pc, 32'h1C00_0008);
        cycle();
        check("t3_empty", upd_valid, 1'b0);

        // 4: redirect held for five cycles
        redir_ready = 0;
        set_br0(32'h1C00_0010, 1, 32'h1C00_0500, 1, 32'h1C00_0600, 1);
        cycle();
        clear_br();
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("t4_hold_pc", redir_pc, 32'h1C00_0500);
            check("t4_hold_flush", flush, 1'b0);
            check("t4_hold_busy", busy, 1'b1);
        end
        redir_ready = 1;
        cycle();
        check("t4_drain_busy", busy, 1'b1);
        cycle();
        check("t4_idle_busy", busy, 1'b0);

        // pc+4 wraps at the top of the address space
        set_br0(32'hFFFF_FFFC, 0, 32'h1234_0000, 1, 32'h1234_0000, 0);
        cycle();
        clear_br();
        check("wrap_redir_pc", redir_pc, 32'h0);
        repeat (3) cycle();

        // 5: fill the FIFO with correct predictions while the predictor stalls
        upd_ready = 0;
        set_br0(32'h1C00_1000, 1, 32'h1C00_2000, 1, 32'h1C00_2000, 0);
        cycle();
        check("t5_busy_1", busy, 1'b0);
        set_br0(32'h1C00_1004, 0, 32'h1C00_3000, 0, 32'h0, 0);
        cycle();
        check("t5_busy_2", busy, 1'b0);
        set_br0(32'h1C00_1008, 1, 32'h1C00_4000, 1, 32'h1C00_4000, 1);
        set_br1(32'h1C00_100C, 0, 32'h1C00_5000, 0, 32'h0, 0);
        cycle();
        clear_br();
        check("t5_busy_full", busy, 1'b1);
        repeat (2) cycle();
        check("t5_full_head", upd_pc, 32'h1C00_1000);
        upd_ready = 1;
        cycle();
        check("t5_pop2", upd_pc, 32'h1C00_1004);
        cycle();
        check("t5_pop3", upd_pc, 32'h1C00_1008);
        cycle();
        check("t5_pop4", upd_pc, 32'h1C00_100C);
        cycle();
        check("t5_empty", upd_valid, 1'b0);

        // 6: reset in the middle of a redirect
        upd_ready = 0; redir_ready = 0;
        set_br0(32'h1C00_0020, 1, 32'h1C00_0700, 0, 32'h0, 0);
        cycle();
        clear_br();
        cycle();
        rst = 1;
        cycle();
        check("t6_redir_valid", redir_valid, 1'b0);
        check("t6_flush", flush, 1'b0);
        check("t6_busy", busy, 1'b0);
        check("t6_upd_valid", upd_valid, 1'b0);
        rst = 0;
        cycle();

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            clear_br();
            redir_ready = ($urandom_range(0, 2) != 0);
            upd_ready   = 1'($urandom_range(0, 1));
            if (!m_busy()) begin
                if ($urandom_range(0, 2) != 0) begin
                    rand_br(pc, t, tg, pt, ptg, j);
                    set_br0(pc, t, tg, pt, ptg, j);
                end
                if ($urandom_range(0, 2) != 0) begin
                    rand_br(pc, t, tg, pt, ptg, j);
                    set_br1(pc, t, tg, pt, ptg, j);
                end
            end
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
